// File: rtl/ahb_slave_mem.sv
// AHB-lite word-addressed SRAM responder with programmable wait states and
// two-cycle ERROR responses for unaligned or out-of-window addresses.
module ahb_slave_mem #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSel,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [2:0]  HBurst_Size,
  input  logic [3:0]  HWStrb,
  input  logic [31:0] HWData,
  input  logic        HReady_in,
  output logic [31:0] HRData,
  output logic        HReady_out,
  output logic [1:0]  HResp
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          write_q;
  logic [3:0]    strb_q;
  logic [AW-1:0] idx_q;
  logic [3:0]    cnt;
  logic          hready_q;
  logic [1:0]    hresp_q;

  logic          accept;
  logic          addr_ok;
  logic [32:0]   win_end;
  logic [31:0]   offset;
  logic          unused_ok;

  always_comb begin
    accept  = HSel & HReady_in & HTrans[1];
    win_end = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    addr_ok = (HAddr[1:0] == 2'b00) &&
              ({1'b0, HAddr} >= {1'b0, BASE_ADDR}) &&
              ({1'b0, HAddr} < win_end);
    offset  = HAddr - BASE_ADDR;
  end

  assign unused_ok = &{1'b0, HBurst_Size, offset[31:AW+2], offset[1:0]};

  // Address phase is evaluated in IDLE, DATA and ERR2; WAIT/ERR1 ignore the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
      cnt      <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
      idx_q    <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= S_DATA;
            hready_q <= 1'b1;
          end
        end
        S_ERR1: begin
          state    <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 2'b01;
        end
        default: begin
          if (accept) begin
            write_q <= HWrite;
            strb_q  <= HWStrb;
            idx_q   <= offset[AW+1:2];
            if (!addr_ok) begin
              state    <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 2'b01;
            end else if (WAIT_STATES != 0) begin
              state    <= S_WAIT;
              hready_q <= 1'b0;
              hresp_q  <= 2'b00;
              cnt      <= 4'(WAIT_STATES);
            end else begin
              state    <= S_DATA;
              hready_q <= 1'b1;
              hresp_q  <= 2'b00;
            end
          end else begin
            state    <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 2'b00;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_DATA && write_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= HWData[8*i +: 8];
      end
    end
  end

  assign HRData     = (state == S_DATA && !write_q) ? mem[idx_q] : '0;
  assign HReady_out = hready_q;
  assign HResp      = hresp_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances with 0, 1 and 2 wait
// states share one bus; each instance's HReady_out feeds its own HReady_in.
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [3:0]  hwstrb;
  logic [31:0] hwdata;
  logic [2:0]  rdy;
  logic [1:0]  resp  [3];
  logic [31:0] rdata [3];

  int checks = 0;
  int errors = 0;
  int d = 0;

  logic [31:0] b_addr [8];
  logic [31:0] b_data [8];
  logic [31:0] b_exp  [8];
  logic        b_wr   [8];
  logic        b_err  [8];
  logic        b_seq  [8];
  logic [3:0]  b_strb [8];

  always #5 clk = ~clk;

  ahb_slave_mem #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .HSel(sel[0]), .HAddr(haddr), .HTrans(htrans),
    .HWrite(hwrite), .HBurst_Size(3'b001), .HWStrb(hwstrb), .HWData(hwdata),
    .HReady_in(rdy[0]), .HRData(rdata[0]), .HReady_out(rdy[0]), .HResp(resp[0]));

  ahb_slave_mem #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(1)) u1 (
    .clk(clk), .rst(rst), .HSel(sel[1]), .HAddr(haddr), .HTrans(htrans),
    .HWrite(hwrite), .HBurst_Size(3'b001), .HWStrb(hwstrb), .HWData(hwdata),
    .HReady_in(rdy[1]), .HRData(rdata[1]), .HReady_out(rdy[1]), .HResp(resp[1]));

  ahb_slave_mem #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst), .HSel(sel[2]), .HAddr(haddr), .HTrans(htrans),
    .HWrite(hwrite), .HBurst_Size(3'b001), .HWStrb(hwstrb), .HWData(hwdata),
    .HReady_in(rdy[2]), .HRData(rdata[2]), .HReady_out(rdy[2]), .HResp(resp[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int i, input logic [31:0] addr, input logic wr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp, input logic err, input logic seq);
    b_addr[i] = addr; b_wr[i] = wr; b_data[i] = data; b_strb[i] = strb;
    b_exp[i] = exp; b_err[i] = err; b_seq[i] = seq;
  endtask

  task automatic present(input int i);
    sel[d] = 1'b1;
    htrans = b_seq[i] ? 2'b11 : 2'b10;
    haddr  = b_addr[i];
    hwrite = b_wr[i];
    hwstrb = b_strb[i];
  endtask

  task automatic go_idle();
    sel    = '0;
    htrans = 2'b00;
  endtask

  // Pipelined run of n beats on instance d; called and returns on a negedge.
  task automatic run_seq(input int n, input int ws);
    int waits;
    present(0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); @(negedge clk);
      hwdata = b_data[k];
      if (k + 1 < n) present(k + 1);
      else go_idle();
      waits = 0;
      while (rdy[d] == 1'b0 && waits < 20) begin
        chk($sformatf("stall resp d%0d b%0d", d, k), 32'(resp[d]), b_err[k] ? 32'd1 : 32'd0);
        waits++;
        @(posedge clk); @(negedge clk);
      end
      chk($sformatf("wait count d%0d b%0d", d, k), 32'(waits), b_err[k] ? 32'd1 : 32'(ws));
      chk($sformatf("resp d%0d b%0d", d, k), 32'(resp[d]), b_err[k] ? 32'd1 : 32'd0);
      chk($sformatf("rdata d%0d b%0d", d, k), rdata[d], b_exp[k]);
    end
    @(posedge clk); @(negedge clk);
    chk($sformatf("idle ready d%0d", d), 32'(rdy[d]), 32'd1);
    chk($sformatf("idle resp d%0d", d), 32'(resp[d]), 32'd0);
  endtask

  initial begin
    rst = 1'b1; go_idle(); haddr = '0; hwrite = 1'b0; hwstrb = '0; hwdata = '0;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset ready d%0d", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("reset resp d%0d", i), 32'(resp[i]), 32'd0);
      chk($sformatf("reset rdata d%0d", i), rdata[i], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    // zero wait states: write then read back-to-back
    d = 0;
    beat(0, 32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    beat(1, 32'h1000, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    run_seq(2, 0);

    // two wait states
    d = 2;
    beat(0, 32'h1004, 1'b1, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1'b0);
    beat(1, 32'h1004, 1'b0, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1'b0);
    run_seq(2, 2);

    // byte strobes
    d = 1;
    beat(0, 32'h1008, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0);
    beat(1, 32'h1008, 1'b1, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, 1'b0);
    beat(2, 32'h1008, 1'b0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b0);
    run_seq(3, 1);

    // errors: both bad addresses would alias word 0 if not rejected
    beat(0, 32'h1000, 1'b1, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0);
    beat(1, 32'h1002, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b0);
    beat(2, 32'h1400, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b0);
    beat(3, 32'h1000, 1'b0, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b0);
    beat(4, 32'h1400, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    run_seq(5, 1);

    // 4-beat SEQ write burst followed by INCR read burst
    for (int i = 0; i < 4; i++)
      beat(i, 32'h1010 + 32'(4 * i), 1'b1, 32'hA0000000 + 32'(i * 32'h0101), 4'hF,
           32'h0, 1'b0, i != 0);
    for (int i = 0; i < 4; i++)
      beat(4 + i, 32'h1010 + 32'(4 * i), 1'b0, 32'h0, 4'h0,
           32'hA0000000 + 32'(i * 32'h0101), 1'b0, i != 0);
    run_seq(8, 1);

    // reset during WAIT of a write abandons it
    beat(0, 32'h1020, 1'b1, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, 1'b0);
    run_seq(1, 1);
    beat(0, 32'h1020, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b0);
    present(0);
    @(posedge clk); @(negedge clk);
    go_idle();
    hwdata = 32'hFFFFFFFF;
    chk("wait before reset", 32'(rdy[1]), 32'd0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("ready after reset", 32'(rdy[1]), 32'd1);
    chk("resp after reset", 32'(resp[1]), 32'd0);
    chk("rdata after reset", rdata[1], 32'd0);
    @(posedge clk); @(negedge clk);
    beat(0, 32'h1020, 1'b0, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, 1'b0);
    run_seq(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
